// File: rtl/pos_link_pkg.sv
// pos_link_pkg: shared frame constants, FSM encodings and checksum helper for the position link.
package pos_link_pkg;
  localparam int FRAME_LEN = 6;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  typedef enum logic {T_IDLE, T_SEND} tx_state_e;
  typedef enum logic [2:0] {R_HUNT, R_B1, R_B2, R_B3, R_B4, R_CHK} rx_state_e;
  function automatic logic [7:0] frame_csum(input logic [7:0] b1, b2, b3, b4);
    return b1 ^ b2 ^ b3 ^ b4;
  endfunction
endpackage

// File: rtl/pos_link_ctrl_if.sv
// pos_link_ctrl_if: joystick/vga side inputs, uart byte FIFO handshakes and remote-position outputs.
interface pos_link_ctrl_if;
  logic       vsync;
  logic [9:0] x_local, y_local;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] x_remote, y_remote;
  logic       frame_ok, frame_err, link_up;
  modport master(input vsync, x_local, y_local, tx_ready, rx_data, rx_valid,
                 output tx_data, tx_wr, x_remote, y_remote, frame_ok, frame_err, link_up);
  modport slave(output vsync, x_local, y_local, tx_ready, rx_data, rx_valid,
                input tx_data, tx_wr, x_remote, y_remote, frame_ok, frame_err, link_up);
endinterface

// File: rtl/pos_frame_rx.sv
// pos_frame_rx: parses incoming position frames, runs inter-byte and link timers, holds remote position.
import pos_link_pkg::*;
module pos_frame_rx #(
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         BYTE_TIMEOUT = 65000,
  parameter int         LINK_TIMEOUT = 6500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [9:0] x_remote_o,
  output logic [9:0] y_remote_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic       link_up_o
);
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  rx_state_e       st_q;
  logic [3:0][7:0] b_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [LW-1:0]   link_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= R_HUNT;
      b_q         <= '0;
      byte_cnt_q  <= '0;
      link_cnt_q  <= '0;
      x_remote_o  <= '0;
      y_remote_o  <= '0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      link_up_o   <= 1'b0;
    end else begin
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      link_cnt_q  <= link_cnt_q == LW'(LINK_TIMEOUT) ? link_cnt_q : link_cnt_q + 1'b1;
      if (link_cnt_q == LW'(LINK_TIMEOUT)) link_up_o <= 1'b0;
      byte_cnt_q  <= rx_valid_i || st_q == R_HUNT ? '0 : byte_cnt_q + 1'b1;
      // a byte arriving in the same cycle as the timeout wins over the timeout
      if (rx_valid_i) begin
        case (st_q)
          R_HUNT: if (rx_data_i == SYNC_BYTE) st_q <= R_B1;
          R_CHK: begin
            st_q <= R_HUNT;
            if (rx_data_i == frame_csum(b_q[3], b_q[2], b_q[1], b_q[0])) begin
              x_remote_o <= {b_q[3][1:0], b_q[2]};
              y_remote_o <= {b_q[1][1:0], b_q[0]};
              frame_ok_o <= 1'b1;
              link_cnt_q <= '0;
              link_up_o  <= 1'b1;
            end else frame_err_o <= 1'b1;
          end
          default: begin
            b_q  <= {b_q[2:0], rx_data_i};
            st_q <= rx_state_e'(st_q + 3'd1);
          end
        endcase
      end else if (st_q != R_HUNT && byte_cnt_q == BW'(BYTE_TIMEOUT)) begin
        frame_err_o <= 1'b1;
        st_q        <= R_HUNT;
        byte_cnt_q  <= '0;
      end
    end
  end
endmodule

// File: rtl/pos_link_ctrl.sv
// pos_link_ctrl: sends the local position once per FRAME_DIV vsync edges and publishes the validated remote position.
import pos_link_pkg::*;
module pos_link_ctrl #(
  parameter int         FRAME_DIV    = 1,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         BYTE_TIMEOUT = 65000,
  parameter int         LINK_TIMEOUT = 6500000
) (
  input logic clk,
  input logic rst,
  pos_link_ctrl_if.master link
);
  tx_state_e  tx_st_q;
  logic       vsync_q;
  logic [3:0] div_q;
  logic [2:0] idx_q;
  logic [9:0] x_q, y_q;
  logic [7:0] csum_q;
  logic       vs_rise, fire;
  assign vs_rise = link.vsync & ~vsync_q;
  assign fire    = vs_rise && div_q == 4'(FRAME_DIV - 1);
  always_comb begin
    link.tx_wr   = tx_st_q == T_SEND && link.tx_ready;
    link.tx_data = tx_st_q != T_SEND ? 8'h00 :
                   idx_q == 3'd0     ? SYNC_BYTE :
                   idx_q == 3'd1     ? {6'b0, x_q[9:8]} :
                   idx_q == 3'd2     ? x_q[7:0] :
                   idx_q == 3'd3     ? {6'b0, y_q[9:8]} :
                   idx_q == 3'd4     ? y_q[7:0] : csum_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q <= T_IDLE;
      vsync_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      csum_q  <= '0;
    end else begin
      vsync_q <= link.vsync;
      if (vs_rise) div_q <= fire ? '0 : div_q + 4'd1;
      // a fire during T_SEND is simply ignored so the frame in flight stays intact
      if (tx_st_q == T_IDLE) begin
        if (fire) begin
          tx_st_q <= T_SEND;
          idx_q   <= '0;
          x_q     <= link.x_local;
          y_q     <= link.y_local;
          csum_q  <= frame_csum({6'b0, link.x_local[9:8]}, link.x_local[7:0],
                                {6'b0, link.y_local[9:8]}, link.y_local[7:0]);
        end
      end else if (link.tx_ready) begin
        idx_q <= idx_q + 3'd1;
        if (idx_q == 3'(FRAME_LEN - 1)) tx_st_q <= T_IDLE;
      end
    end
  end
  pos_frame_rx #(.SYNC_BYTE(SYNC_BYTE), .BYTE_TIMEOUT(BYTE_TIMEOUT), .LINK_TIMEOUT(LINK_TIMEOUT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (link.rx_data),
    .rx_valid_i (link.rx_valid),
    .x_remote_o (link.x_remote),
    .y_remote_o (link.y_remote),
    .frame_ok_o (link.frame_ok),
    .frame_err_o(link.frame_err),
    .link_up_o  (link.link_up)
  );
endmodule

// File: tb/tb_pos_link_ctrl.sv
// tb_pos_link_ctrl: scoreboard bench for the position link, with short timeouts to keep runtime small.
module tb_pos_link_ctrl;
  localparam int BT = 200;
  localparam int LT = 3000;
  typedef struct {logic err; logic [9:0] x, y;} rx_exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0, cnt3 = 0;
  logic [7:0] tq[$];
  rx_exp_t    rq[$];
  logic [9:0] hold_x = '0, hold_y = '0;
  pos_link_ctrl_if bus();
  pos_link_ctrl_if bus3();
  pos_link_ctrl #(.FRAME_DIV(1), .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut (.clk(clk), .rst(rst), .link(bus));
  pos_link_ctrl #(.FRAME_DIV(3), .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)) dut3 (.clk(clk), .rst(rst), .link(bus3));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void push_frame(input logic [9:0] x, input logic [9:0] y);
    logic [7:0] b1, b2, b3, b4;
    b1 = {6'b0, x[9:8]}; b2 = x[7:0]; b3 = {6'b0, y[9:8]}; b4 = y[7:0];
    tq.push_back(8'hA5); tq.push_back(b1); tq.push_back(b2);
    tq.push_back(b3); tq.push_back(b4); tq.push_back(b1 ^ b2 ^ b3 ^ b4);
  endfunction
  always @(negedge clk) begin
    if (bus.tx_wr) begin
      check("tx_gate", {31'b0, bus.tx_ready}, 1);
      if (tq.size() == 0) check("tx_extra", {31'b0, bus.tx_wr}, 0);
      else check("tx_byte", {24'b0, bus.tx_data}, {24'b0, tq.pop_front()});
    end
    if (bus.frame_ok || bus.frame_err) begin
      if (rq.size() == 0) check("rx_extra", {31'b0, bus.frame_ok | bus.frame_err}, 0);
      else begin
        rx_exp_t e;
        e = rq.pop_front();
        check("rx_kind", {30'b0, bus.frame_err, bus.frame_ok}, e.err ? 2 : 1);
        check("rx_x", {22'b0, bus.x_remote}, {22'b0, e.x});
        check("rx_y", {22'b0, bus.y_remote}, {22'b0, e.y});
      end
    end
    if (bus3.tx_wr) cnt3++;
  end
  task automatic vs_pulse(input logic [9:0] x, input logic [9:0] y);
    @(posedge clk); #1;
    bus.x_local = x; bus.y_local = y; bus.vsync = 1'b1;
    push_frame(x, y);
    @(posedge clk); #1 bus.vsync = 1'b0;
  endtask
  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk); #1 bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1 bus.rx_valid = 1'b0;
  endtask
  task automatic rx_frame(input logic [9:0] x, input logic [9:0] y, input logic [7:0] flip);
    logic [7:0] b1, b2, b3, b4;
    b1 = {6'b0, x[9:8]}; b2 = x[7:0]; b3 = {6'b0, y[9:8]}; b4 = y[7:0];
    rx_byte(8'hA5); rx_byte(b1); rx_byte(b2); rx_byte(b3); rx_byte(b4);
    rx_byte(b1 ^ b2 ^ b3 ^ b4 ^ flip);
  endtask
  task automatic drain(input int bound);
    for (int i = 0; i < bound && (tq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
    check("tx_drain", tq.size(), 0);
    check("rx_drain", rq.size(), 0);
  endtask
  initial begin
    bus.vsync = 1'b0; bus.x_local = '0; bus.y_local = '0; bus.tx_ready = 1'b1;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus3.vsync = 1'b0; bus3.x_local = 10'h0F0; bus3.y_local = 10'h00F; bus3.tx_ready = 1'b1;
    bus3.rx_data = '0; bus3.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // T1: async reset in the middle of a tx frame and an rx frame
    vs_pulse(10'h2AB, 10'h155);
    rx_byte(8'hA5);
    rx_byte(8'h02);
    @(posedge clk); #3 rst = 1'b1;
    tq.delete();
    #1;
    check("rst_tx_wr", {31'b0, bus.tx_wr}, 0);
    check("rst_tx_data", {24'b0, bus.tx_data}, 0);
    check("rst_x_remote", {22'b0, bus.x_remote}, 0);
    check("rst_y_remote", {22'b0, bus.y_remote}, 0);
    check("rst_frame_ok", {31'b0, bus.frame_ok}, 0);
    check("rst_frame_err", {31'b0, bus.frame_err}, 0);
    check("rst_link_up", {31'b0, bus.link_up}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_byte(8'hAB); rx_byte(8'h01); rx_byte(8'h55); rx_byte(8'hFD);
    repeat (10) @(posedge clk);
    #1 check("post_rst_idle", {31'b0, bus.tx_wr}, 0);
    // T2: plain send with tx_ready held high
    vs_pulse(10'h2AB, 10'h155);
    drain(40);
    // T3: random backpressure with a dropped mid-frame vsync edge
    begin
      bit dropped;
      dropped = 1'b0;
      @(posedge clk); #1;
      bus.x_local = 10'h3FF; bus.y_local = 10'h000; bus.vsync = 1'b1;
      push_frame(10'h3FF, 10'h000);
      for (int i = 0; i < 400 && tq.size() != 0; i++) begin
        @(posedge clk); #1;
        bus.tx_ready = 1'($urandom_range(0, 1));
        bus.vsync = 1'b0;
        if (!dropped && tq.size() == 3) begin
          bus.vsync = 1'b1;
          bus.x_local = 10'h111;
          dropped = 1'b1;
        end
      end
      bus.vsync = 1'b0;
      bus.tx_ready = 1'b1;
      check("t3_dropped_seen", {31'b0, dropped}, 1);
      repeat (20) @(posedge clk);
      drain(10);
    end
    // T4: good frame preceded by garbage
    rx_byte(8'h00); rx_byte(8'hA6);
    rq.push_back('{1'b0, 10'h2AB, 10'h155});
    hold_x = 10'h2AB; hold_y = 10'h155;
    rx_frame(10'h2AB, 10'h155, 8'h00);
    drain(10);
    #1 check("t4_link_up", {31'b0, bus.link_up}, 1);
    // T5: bad checksum, then inter-byte timeout, then resync with SYNC_BYTE inside the payload
    rq.push_back('{1'b1, hold_x, hold_y});
    rx_frame(10'h123, 10'h234, 8'h01);
    drain(10);
    rq.push_back('{1'b1, hold_x, hold_y});
    rx_byte(8'hA5); rx_byte(8'h03); rx_byte(8'h11);
    drain(BT + 20);
    rq.push_back('{1'b0, 10'h1A5, 10'h2EE});
    hold_x = 10'h1A5; hold_y = 10'h2EE;
    rx_frame(10'h1A5, 10'h2EE, 8'h00);
    drain(10);
    // T6: divide-by-3 sender, then link timeout
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1 bus3.vsync = 1'b1;
      @(posedge clk); #1 bus3.vsync = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      if (e == 2) check("div3_after2", cnt3, 0);
      if (e == 3) check("div3_after3", cnt3, 6);
      if (e == 9) check("div3_after9", cnt3, 18);
    end
    check("link_still_up", {31'b0, bus.link_up}, 1);
    repeat (LT + 20) @(posedge clk);
    #1;
    check("link_down", {31'b0, bus.link_up}, 0);
    check("hold_x", {22'b0, bus.x_remote}, {22'b0, hold_x});
    check("hold_y", {22'b0, bus.y_remote}, {22'b0, hold_y});
    drain(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
